// File: rtl/serial_comparator_msb_pkg.sv
// Shared types and constants for the MSB-first serial magnitude comparator.
// The optional CMP_EARLY_EXIT_EN build changes only latency, never results.
package serial_comparator_msb_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

  // Result code to {F_eq, F_gt, F_lt}; exactly one bit set.
  function automatic logic [2:0] flags_of(input logic [1:0] res);
    case (res)
      RES_GT:  flags_of = 3'b010;
      RES_LT:  flags_of = 3'b001;
      default: flags_of = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/serial_comparator_msb_if.sv
// Start/done handshake, operand and result bundle for serial_comparator_msb.
interface serial_comparator_msb_if
  import serial_comparator_msb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             F_eq;
  logic             F_gt;
  logic             F_lt;

  modport master (
    output start, A, B,
    input  busy, done, F_eq, F_gt, F_lt
  );

  modport slave (
    input  start, A, B,
    output busy, done, F_eq, F_gt, F_lt
  );

endinterface

// File: rtl/serial_comparator_msb_cmp_slice_4b.sv
// Combinational unsigned compare of one slice; a single instance is shared
// across all slices by the top-level index mux.
module cmp_slice_4b #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_comparator_msb.sv
// MSB-first multi-cycle unsigned comparator, one slice per clock.
// Define CMP_EARLY_EXIT_EN to stop at the first differing slice.
//
// state | meaning
// IDLE  | waiting for start; flags hold the last result
// SCAN  | comparing slice `index` of the latched operands, MSB first
module serial_comparator_msb
  import serial_comparator_msb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input logic                  clk,
  input logic                  rst,
  serial_comparator_msb_if.slave bus
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  state_t           state;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       flags_q;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic             s_eq;
  logic             s_gt;
  logic             s_lt;
  logic [1:0]       slice_res;

`ifndef CMP_EARLY_EXIT_EN
  // First differing slice from the MSB; lower slices must not overwrite it.
  logic             decided;
  logic [1:0]       res_q;
`endif

  assign a_slice = a_q[int'(index)*SLICE +: SLICE];
  assign b_slice = b_q[int'(index)*SLICE +: SLICE];

  cmp_slice_4b #(.SLICE(SLICE)) u_slice (
    .a  (a_slice),
    .b  (b_slice),
    .eq (s_eq),
    .gt (s_gt),
    .lt (s_lt)
  );

  assign slice_res = s_gt ? RES_GT : (s_lt ? RES_LT : RES_EQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= 3'b000;
`ifndef CMP_EARLY_EXIT_EN
      decided <= 1'b0;
      res_q   <= RES_EQ;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            index   <= IW'(NS - 1);
            flags_q <= 3'b000;
            busy_q  <= 1'b1;
            state   <= SCAN;
`ifndef CMP_EARLY_EXIT_EN
            decided <= 1'b0;
            res_q   <= RES_EQ;
`endif
          end
        end
        SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
          if (!s_eq || index == '0) begin
            flags_q <= flags_of(slice_res);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            index <= index - IW'(1);
          end
`else
          if (!decided && !s_eq) begin
            decided <= 1'b1;
            res_q   <= slice_res;
          end
          if (index == '0) begin
            flags_q <= flags_of(decided ? res_q : slice_res);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            index <= index - IW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.F_eq = flags_q[2];
  assign bus.F_gt = flags_q[1];
  assign bus.F_lt = flags_q[0];

endmodule
